// File: rtl/regfile_wb_if.sv
// Result-source handshakes, issue-stage allocation and register file write port
// for the integer register file write-back stage.
interface regfile_wb_if #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int REG_NUM = 2**ADDR_W
);
  logic              flush;
  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              lsu_valid;
  logic              lsu_ready;
  logic [ADDR_W-1:0] lsu_rd;
  logic [DATA_W-1:0] lsu_data;
  logic              iss_set;
  logic [ADDR_W-1:0] iss_rd;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [REG_NUM-1:0] pend;

  modport master (
    output flush, alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
           iss_set, iss_rd,
    input  alu_ready, lsu_ready, we, waddr, wdata, pend
  );

  modport slave (
    input  flush, alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
           iss_set, iss_rd,
    output alu_ready, lsu_ready, we, waddr, wdata, pend
  );
endinterface

// File: rtl/regfile_wb.sv
// Register file write-back: round-robin merge of ALU and LSU results onto the
// single write port, plus the pending-write bitmap used for RAW hazard checks.
module regfile_wb #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int REG_NUM = 2**ADDR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_wb_if.slave  bus
);

  typedef enum logic {SRC_ALU = 1'b0, SRC_LSU = 1'b1} src_e;

  localparam logic [REG_NUM-1:0] BIT0 = {{(REG_NUM-1){1'b0}}, 1'b1};

  src_e               last_r;
  src_e               last_nxt_s;
  logic               grant_alu_s;
  logic               grant_lsu_s;
  logic               xfer_s;
  logic [ADDR_W-1:0]  xfer_rd_s;
  logic [DATA_W-1:0]  xfer_data_s;
  logic [REG_NUM-1:0] clr_mask_s;
  logic [REG_NUM-1:0] set_mask_s;
  logic [REG_NUM-1:0] pend_nxt_s;
  logic               we_r;
  logic [ADDR_W-1:0]  waddr_r;
  logic [DATA_W-1:0]  wdata_r;
  logic [REG_NUM-1:0] pend_r;

  // Arbitration: a tie goes to the source that was not granted last
  always_comb begin
    grant_alu_s = 1'b0;
    grant_lsu_s = 1'b0;
    case ({bus.alu_valid, bus.lsu_valid})
      2'b10:   grant_alu_s = 1'b1;
      2'b01:   grant_lsu_s = 1'b1;
      2'b11: begin
        if (last_r == SRC_ALU) begin
          grant_lsu_s = 1'b1;
        end else begin
          grant_alu_s = 1'b1;
        end
      end
      default: begin
        grant_alu_s = 1'b0;
        grant_lsu_s = 1'b0;
      end
    endcase
  end

  assign bus.alu_ready = grant_alu_s & ~bus.flush & rst_n;
  assign bus.lsu_ready = grant_lsu_s & ~bus.flush & rst_n;

  // Select the transferring source and the next round-robin pointer
  always_comb begin
    xfer_s      = 1'b0;
    xfer_rd_s   = '0;
    xfer_data_s = '0;
    last_nxt_s  = last_r;
    if (bus.alu_valid && bus.alu_ready) begin
      xfer_s      = 1'b1;
      xfer_rd_s   = bus.alu_rd;
      xfer_data_s = bus.alu_data;
      last_nxt_s  = SRC_ALU;
    end else if (bus.lsu_valid && bus.lsu_ready) begin
      xfer_s      = 1'b1;
      xfer_rd_s   = bus.lsu_rd;
      xfer_data_s = bus.lsu_data;
      last_nxt_s  = SRC_LSU;
    end else begin
      xfer_s      = 1'b0;
    end
  end

  // Scoreboard next state: the set is applied after the clear so a fresh allocation wins
  always_comb begin
    clr_mask_s = xfer_s ? (BIT0 << xfer_rd_s) : '0;
    set_mask_s = (bus.iss_set && (bus.iss_rd != '0)) ? (BIT0 << bus.iss_rd) : '0;
    pend_nxt_s = (pend_r & ~clr_mask_s) | set_mask_s;
    pend_nxt_s[0] = 1'b0;
  end

  // Registered write port, round-robin pointer and pending bitmap
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_r    <= 1'b0;
      waddr_r <= '0;
      wdata_r <= '0;
      pend_r  <= '0;
      last_r  <= SRC_ALU;
    end else begin
      we_r   <= xfer_s && (xfer_rd_s != '0);
      last_r <= last_nxt_s;
      pend_r <= bus.flush ? '0 : pend_nxt_s;
      if (xfer_s) begin
        waddr_r <= xfer_rd_s;
        wdata_r <= xfer_data_s;
      end else begin
        waddr_r <= waddr_r;
        wdata_r <= wdata_r;
      end
    end
  end

  assign bus.we    = we_r;
  assign bus.waddr = waddr_r;
  assign bus.wdata = wdata_r;
  assign bus.pend  = pend_r;

endmodule

// File: tb/tb_regfile_wb.sv
// Directed, table-driven bench for regfile_wb: one vector per clock, ready
// checked before the edge, registered outputs checked just after it.
module tb_regfile_wb;

  logic clk;
  logic rst_n;

  regfile_wb_if #(.ADDR_W(5), .DATA_W(32), .REG_NUM(32)) bus ();

  regfile_wb #(.ADDR_W(5), .DATA_W(32), .REG_NUM(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adat;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldat;
    logic        iss;
    logic [4:0]  isrd;
    logic        fl;
    logic        e_ar;
    logic        e_lr;
    logic        e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic [31:0] e_pend;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t tbl[23];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    bus.alu_valid = v.av;
    bus.alu_rd    = v.ard;
    bus.alu_data  = v.adat;
    bus.lsu_valid = v.lv;
    bus.lsu_rd    = v.lrd;
    bus.lsu_data  = v.ldat;
    bus.iss_set   = v.iss;
    bus.iss_rd    = v.isrd;
    bus.flush     = v.fl;
    #1;
    chk({tag, ".alu_ready"}, {31'd0, bus.alu_ready}, {31'd0, v.e_ar});
    chk({tag, ".lsu_ready"}, {31'd0, bus.lsu_ready}, {31'd0, v.e_lr});
    @(posedge clk);
    #1;
    chk({tag, ".we"},    {31'd0, bus.we},    {31'd0, v.e_we});
    chk({tag, ".waddr"}, {27'd0, bus.waddr}, {27'd0, v.e_wa});
    chk({tag, ".wdata"}, bus.wdata, v.e_wd);
    chk({tag, ".pend"},  bus.pend,  v.e_pend);
  endtask

  initial begin
    vec_t v;
    //          av   ard    adat          lv   lrd    ldat          iss  isrd   fl    ar   lr   we   wa     wd            pend
    tbl[0]  = '{1'b1,5'd5, 32'h1234_5678,1'b0,5'd0, 32'h0,        1'b0,5'd0, 1'b0, 1'b1,1'b0,1'b1,5'd5, 32'h1234_5678,32'h0};
    tbl[1]  = '{1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b0,5'd0, 1'b0, 1'b0,1'b0,1'b0,5'd5, 32'h1234_5678,32'h0};
    tbl[2]  = '{1'b1,5'd1, 32'hA1,       1'b1,5'd4, 32'hB4,       1'b0,5'd0, 1'b0, 1'b0,1'b1,1'b1,5'd4, 32'hB4,       32'h0};
    tbl[3]  = '{1'b1,5'd1, 32'hA1,       1'b1,5'd5, 32'hB5,       1'b0,5'd0, 1'b0, 1'b1,1'b0,1'b1,5'd1, 32'hA1,       32'h0};
    tbl[4]  = '{1'b1,5'd2, 32'hA2,       1'b1,5'd5, 32'hB5,       1'b0,5'd0, 1'b0, 1'b0,1'b1,1'b1,5'd5, 32'hB5,       32'h0};
    tbl[5]  = '{1'b1,5'd2, 32'hA2,       1'b0,5'd0, 32'h0,        1'b0,5'd0, 1'b0, 1'b1,1'b0,1'b1,5'd2, 32'hA2,       32'h0};
    tbl[6]  = '{1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b0,5'd0, 1'b0, 1'b0,1'b0,1'b0,5'd2, 32'hA2,       32'h0};
    tbl[7]  = '{1'b1,5'd0, 32'hFFFF_FFFF,1'b0,5'd0, 32'h0,        1'b0,5'd0, 1'b0, 1'b1,1'b0,1'b0,5'd0, 32'hFFFF_FFFF,32'h0};
    tbl[8]  = '{1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b1,5'd7, 1'b0, 1'b0,1'b0,1'b0,5'd0, 32'hFFFF_FFFF,32'h80};
    tbl[9]  = '{1'b0,5'd0, 32'h0,        1'b1,5'd7, 32'h77,       1'b0,5'd0, 1'b0, 1'b0,1'b1,1'b1,5'd7, 32'h77,       32'h0};
    tbl[10] = '{1'b1,5'd7, 32'h88,       1'b0,5'd0, 32'h0,        1'b1,5'd7, 1'b0, 1'b1,1'b0,1'b1,5'd7, 32'h88,       32'h80};
    tbl[11] = '{1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b1,5'd4, 1'b0, 1'b0,1'b0,1'b0,5'd7, 32'h88,       32'h90};
    tbl[12] = '{1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b1,5'd5, 1'b0, 1'b0,1'b0,1'b0,5'd7, 32'h88,       32'hB0};
    tbl[13] = '{1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b1,5'd6, 1'b0, 1'b0,1'b0,1'b0,5'd7, 32'h88,       32'hF0};
    tbl[14] = '{1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b1,5'd0, 1'b0, 1'b0,1'b0,1'b0,5'd7, 32'h88,       32'hF0};
    tbl[15] = '{1'b1,5'd3, 32'h33,       1'b0,5'd0, 32'h0,        1'b1,5'd9, 1'b1, 1'b0,1'b0,1'b0,5'd7, 32'h88,       32'h0};
    tbl[16] = '{1'b1,5'd3, 32'h33,       1'b0,5'd0, 32'h0,        1'b0,5'd0, 1'b0, 1'b1,1'b0,1'b1,5'd3, 32'h33,       32'h0};
    tbl[17] = '{1'b1,5'd10,32'hAA,       1'b1,5'd11,32'hBB,       1'b0,5'd0, 1'b1, 1'b0,1'b0,1'b0,5'd3, 32'h33,       32'h0};
    tbl[18] = '{1'b1,5'd10,32'hAA,       1'b1,5'd11,32'hBB,       1'b0,5'd0, 1'b0, 1'b0,1'b1,1'b1,5'd11,32'hBB,       32'h0};
    tbl[19] = '{1'b1,5'd10,32'hAA,       1'b0,5'd0, 32'h0,        1'b0,5'd0, 1'b0, 1'b1,1'b0,1'b1,5'd10,32'hAA,       32'h0};
    tbl[20] = '{1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b1,5'd12,1'b0, 1'b0,1'b0,1'b0,5'd10,32'hAA,       32'h1000};
    tbl[21] = '{1'b0,5'd0, 32'h0,        1'b1,5'd3, 32'h3C,       1'b1,5'd14,1'b0, 1'b0,1'b1,1'b1,5'd3, 32'h3C,       32'h5000};
    tbl[22] = '{1'b1,5'd12,32'hC0,       1'b0,5'd0, 32'h0,        1'b0,5'd0, 1'b0, 1'b1,1'b0,1'b1,5'd12,32'hC0,       32'h4000};

    // Reset held two cycles with an ALU request pending
    rst_n         = 1'b0;
    bus.flush     = 1'b0;
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd5;
    bus.alu_data  = 32'h1234_5678;
    bus.lsu_valid = 1'b0;
    bus.lsu_rd    = 5'd0;
    bus.lsu_data  = 32'h0;
    bus.iss_set   = 1'b0;
    bus.iss_rd    = 5'd0;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk($sformatf("rst%0d.alu_ready", c), {31'd0, bus.alu_ready}, 32'd0);
      @(posedge clk);
      #1;
      chk($sformatf("rst%0d.we", c),    {31'd0, bus.we},    32'd0);
      chk($sformatf("rst%0d.waddr", c), {27'd0, bus.waddr}, 32'd0);
      chk($sformatf("rst%0d.wdata", c), bus.wdata,          32'd0);
      chk($sformatf("rst%0d.pend", c),  bus.pend,           32'd0);
    end
    rst_n = 1'b1;

    for (int i = 0; i < 23; i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // Back-to-back ALU stream, no bubbles on the write port
    for (int i = 1; i <= 8; i++) begin
      v = '{1'b1, 5'(i), 32'h1111_1111 * 32'(i), 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0,
            1'b1, 1'b0, 1'b1, 5'(i), 32'h1111_1111 * 32'(i), 32'h4000};
      apply(v, $sformatf("b2b%0d", i));
    end
    v = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0,
          1'b0, 1'b0, 1'b0, 5'd8, 32'h8888_8888, 32'h4000};
    apply(v, "b2b_idle");

    // Reset mid-handshake drops the request and the scoreboard
    rst_n         = 1'b0;
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd9;
    bus.alu_data  = 32'h99;
    #1;
    chk("rst_mid.alu_ready", {31'd0, bus.alu_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("rst_mid.we",    {31'd0, bus.we},    32'd0);
    chk("rst_mid.waddr", {27'd0, bus.waddr}, 32'd0);
    chk("rst_mid.wdata", bus.wdata,          32'd0);
    chk("rst_mid.pend",  bus.pend,           32'd0);
    rst_n         = 1'b1;
    bus.alu_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
